ifu_fetch: RTL and testbench

- Instruction fetch unit sitting on the consuming side of the next-PC logic.
- Owns the architectural fetch PC register. Issues one-at-a-time read requests to instruction memory using a req/gnt + rvalid protocol.
- Buffers the returned word in a single output register with valid/ready toward decode.
- Exports if_pc and if_pc4 to the next-PC logic and accepts its npc result on redirect (resolved branch, j, jal, jr). No delay slot.

---
 rtl/ifu_fetch.sv | 132 +++++++++++++
 tb/tb_ifu_fetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Owns the fetch PC. Issues one read at a time to instruction memory using
// req/gnt + rvalid, and holds the returned word in a single output register
// with a valid/ready handshake toward decode. On a redirect it reloads the PC
// from the next-PC logic and discards whatever is in flight.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   npc_in, redirect          redirect target and strobe from next-PC logic
//   imem_req, imem_addr       read request and its byte address (word aligned)
//   imem_gnt                  request accepted this cycle
//   imem_rvalid, imem_rdata   read return, one per grant
//   if_valid, if_instr        fetched instruction toward decode
//   if_pc, if_pc4             its address and address + 4
//   id_ready                  decode consumes the output this cycle
//   fetch_err                 fetch PC is illegal; fetching halted
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | first cycle after reset release, no request
// REQ     | request pc_q when the output slot is free
// WAIT    | request granted, waiting for rvalid
// DROP    | redirected while waiting; discard the next rvalid
// FAULT   | pc_q illegal; halted until redirect
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    output logic        fetch_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DROP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    // Legal window compared in 33 bits so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] IMEM_LO = {1'b0, IMEM_BASE};
    localparam logic [32:0] IMEM_HI = {1'b0, IMEM_BASE} + {IMEM_WORDS[30:0], 2'b00};

    logic [2:0]  state;
    logic [31:0] pc_q;
    logic [31:0] fly_pc;
    logic        slot_free;
    logic        addr_ok;
    logic        load;

    always_comb begin
        slot_free = !if_valid || id_ready;
        addr_ok   = (pc_q[1:0] == 2'b00) &&
                    ({1'b0, pc_q} >= IMEM_LO) &&
                    ({1'b0, pc_q} <  IMEM_HI);
        // Suppressed during redirect so a grant can never pair with a stale PC.
        imem_req  = (state == S_REQ) && addr_ok && slot_free && !redirect;
        load      = (state == S_WAIT) && imem_rvalid && !redirect;
    end

    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc_q      <= RESET_PC;
            fly_pc    <= '0;
            fetch_err <= 1'b0;
        end else if (redirect) begin
            pc_q      <= npc_in;
            fetch_err <= 1'b0;
            // A transaction still owed by memory must be absorbed in DROP.
            if ((state == S_WAIT || state == S_DROP) && !imem_rvalid) begin
                state <= S_DROP;
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (!addr_ok) begin
                        state     <= S_FAULT;
                        fetch_err <= 1'b1;
                    end else if (imem_req && imem_gnt) begin
                        fly_pc <= pc_q;
                        pc_q   <= pc_q + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: if (imem_rvalid) state <= S_REQ;
                S_DROP: if (imem_rvalid) state <= S_REQ;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register. A load never collides with an occupied slot because
    // the request was only issued while the slot was free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            if_pc4   <= 32'd4;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= fly_pc;
            if_pc4   <= fly_pc + 32'd4;
        end else if (if_valid && id_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] npc_in;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;
    logic        fetch_err;

    int n_chk = 0;
    int n_err = 0;
    int n_deliv = 0;
    int gnt_count = 0;
    int rdelay = 1;
    bit gnt_rand = 1'b0;

    logic [31:0] req_log[$];
    logic [31:0] exp_q[$];

    // responder state
    bit          out_busy = 1'b0;
    int          out_cnt = 0;
    logic [31:0] out_addr = '0;
    logic [31:0] gnt_addr = '0;

    // monitor state
    bit          hold_prev = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    ifu_fetch dut (
        .clk(clk), .reset_n(reset_n), .npc_in(npc_in), .redirect(redirect),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
        .id_ready(id_ready), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2400_0001;
        if (a == 32'h0000_3004) return 32'h2400_0002;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: program order from a start address.
    task automatic rebuild(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect = 1'b1;
        npc_in   = a;
        cyc(1);
        redirect = 1'b0;
    endtask

    task automatic wait_deliv(input int n);
        int k = 0;
        while (n_deliv < n && k < 200) begin
            cyc(1);
            k++;
        end
        chk1("deliv_reached", n_deliv >= n, 1'b1);
    endtask

    task automatic wait_grant();
        int n = gnt_count;
        int k = 0;
        while (gnt_count == n && k < 100) begin
            cyc(1);
            k++;
        end
        chk1("grant_seen", gnt_count > n, 1'b1);
    endtask

    task automatic wait_log(input int idx);
        int k = 0;
        while (req_log.size() <= idx && k < 100) begin
            cyc(1);
            k++;
        end
        chk1("req_seen", req_log.size() > idx, 1'b1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!if_valid && k < 100) begin
            cyc(1);
            k++;
        end
        chk1("valid_seen", if_valid, 1'b1);
    endtask

    task automatic chk_reset_vals();
        chk1("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc4", if_pc4, 32'h4);
        chk1("rst_fetch_err", fetch_err, 1'b0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
    endtask

    // Memory responder: grants at the negedge, returns data after rdelay cycles
    // (rdelay==0 picks 1..4 at random).
    initial begin : responder
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (imem_gnt) begin
                out_busy = 1'b1;
                out_addr = gnt_addr;
                out_cnt  = (rdelay == 0) ? int'($urandom_range(1, 4)) : rdelay;
                gnt_count++;
                req_log.push_back(gnt_addr);
            end
            imem_gnt = 1'b0;
            if (out_busy) begin
                out_cnt--;
                if (out_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(out_addr);
                    out_busy    = 1'b0;
                end
            end
            @(negedge clk);
            if (imem_req) begin
                chk1("single_outstanding", out_busy, 1'b0);
                chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (!gnt_rand || $urandom_range(0, 2) != 0) begin
                    imem_gnt = 1'b1;
                    gnt_addr = imem_addr;
                end
            end
        end
    end

    // Monitor: compares every presented instruction with the scoreboard head.
    initial begin : monitor
        rebuild(RESET_PC);
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rebuild(RESET_PC);
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk1("hold_valid", if_valid, 1'b1);
                    chk("hold_pc", if_pc, prev_pc);
                    chk("hold_instr", if_instr, prev_instr);
                end
                if (if_valid) begin
                    if (exp_q.size() == 0) begin
                        chk1("scoreboard_nonempty", 1'b0, 1'b1);
                    end else begin
                        chk("sb_pc", if_pc, exp_q[0]);
                        chk("sb_instr", if_instr, mem_word(exp_q[0]));
                        chk("sb_pc4", if_pc4, exp_q[0] + 32'd4);
                        if (id_ready) begin
                            void'(exp_q.pop_front());
                            exp_q.push_back(exp_q[$] + 32'd4);
                            n_deliv++;
                        end
                    end
                end
                hold_prev  = if_valid && !id_ready && !redirect;
                prev_pc    = if_pc;
                prev_instr = if_instr;
                if (redirect) rebuild(npc_in);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        int ng;
        int idx;
        int nd;

        reset_n  = 1'b0;
        redirect = 1'b0;
        npc_in   = '0;
        id_ready = 1'b1;
        cyc(3);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        chk1("no_req_on_release", imem_req, 1'b0);
        @(posedge clk);
        #2;

        // sequential fetch, 1-cycle memory
        wait_deliv(2);
        chk("first_req", log_at(0), 32'h0000_3000);
        chk("second_req", log_at(1), 32'h0000_3004);

        // backpressure
        wait_valid();
        id_ready   = 1'b0;
        held_pc    = if_pc;
        held_instr = if_instr;
        ng         = gnt_count;
        repeat (5) begin
            @(negedge clk);
            chk1("bp_valid", if_valid, 1'b1);
            chk("bp_pc", if_pc, held_pc);
            chk("bp_instr", if_instr, held_instr);
            chk1("bp_no_req", imem_req, 1'b0);
            @(posedge clk);
            #2;
        end
        id_ready = 1'b1;
        @(negedge clk);
        chk1("bp_req_on_ready", imem_req, 1'b1);
        chk("bp_no_grant", 32'(gnt_count), 32'(ng));
        @(posedge clk);
        #2;

        // redirect while waiting (WAIT -> DROP)
        rdelay = 3;
        wait_grant();
        do_redirect(32'h0000_3100);
        idx = req_log.size();
        wait_log(idx);
        chk("redir_wait_req", log_at(idx), 32'h0000_3100);
        wait_valid();
        chk("redir_wait_pc", if_pc, 32'h0000_3100);

        // redirect coinciding with rvalid
        rdelay = 2;
        wait_grant();
        cyc(1);
        do_redirect(32'h0000_3040);
        idx = req_log.size();
        @(negedge clk);
        chk1("redir_rv_dropped", if_valid, 1'b0);
        chk1("redir_rv_req", imem_req, 1'b1);
        chk("redir_rv_addr", imem_addr, 32'h0000_3040);
        @(posedge clk);
        #2;
        wait_log(idx);
        chk("redir_rv_req_log", log_at(idx), 32'h0000_3040);

        // faults
        rdelay = 1;
        do_redirect(32'h0000_3002);
        cyc(6);
        repeat (10) begin
            @(negedge clk);
            chk1("fault_misalign_err", fetch_err, 1'b1);
            chk1("fault_misalign_req", imem_req, 1'b0);
            @(posedge clk);
            #2;
        end
        do_redirect(32'h0000_0000);
        cyc(6);
        repeat (10) begin
            @(negedge clk);
            chk1("fault_low_err", fetch_err, 1'b1);
            chk1("fault_low_req", imem_req, 1'b0);
            @(posedge clk);
            #2;
        end
        do_redirect(32'h0000_3000);
        idx = req_log.size();
        @(negedge clk);
        chk1("fault_cleared", fetch_err, 1'b0);
        @(posedge clk);
        #2;
        wait_log(idx);
        chk("fault_resume_req", log_at(idx), 32'h0000_3000);

        // upper boundary: last two legal words, then fault at the end
        nd = n_deliv;
        do_redirect(32'h0000_6FF8);
        cyc(30);
        chk1("top_fault", fetch_err, 1'b1);
        chk("top_deliv", 32'(n_deliv - nd), 32'd2);
        do_redirect(32'h0000_2FFC);
        cyc(6);
        @(negedge clk);
        chk1("below_base_err", fetch_err, 1'b1);
        chk1("below_base_req", imem_req, 1'b0);
        @(posedge clk);
        #2;

        // reset in WAIT, rvalid arrives during reset
        do_redirect(32'h0000_3200);
        rdelay = 3;
        wait_grant();
        reset_n = 1'b0;
        cyc(5);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idx = req_log.size();
        wait_log(idx);
        chk("post_reset_req", log_at(idx), RESET_PC);
        nd = n_deliv;
        wait_deliv(nd + 2);

        // randomized traffic
        gnt_rand = 1'b1;
        rdelay   = 0;
        repeat (3000) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    npc_in = IMEM_BASE + 32'($urandom_range(0, 16383));
                else
                    npc_in = IMEM_BASE + 32'(4 * $urandom_range(0, 4095));
            end else begin
                redirect = 1'b0;
            end
            cyc(1);
        end
        redirect = 1'b0;
        id_ready = 1'b1;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
